// File: rtl/cr_prefix_fe_feeder_pkg.sv
// Shared types and helpers for the prefix feature-counter lane feeder.
package cr_prefixPKG;

  localparam int FE_BLK_BYTES = 1024;
  localparam int FE_NUM_BLKS  = 4;

  typedef enum logic [2:0] {
    ST_PASS,
    ST_REM,
    ST_DRAIN,
    ST_EODB,
    ST_DROP
  } fe_feeder_state_e;

  // Per-word slicing result against the space left in the current block.
  typedef struct packed {
    logic [3:0]  n;
    logic        fill;
    logic [7:0]  head_mask;
    logic [63:0] rem_data;
    logic [2:0]  rem_cnt;
  } fe_split_t;

  function automatic logic [7:0] fe_thermo(input logic [3:0] cnt);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (4'(i) < cnt);
    return m;
  endfunction

  function automatic logic [63:0] fe_byte_mask(input logic [7:0] vb);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{vb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/cr_prefix_fe_lane_split.sv
// Combinational word slicer: byte count, head lanes that fit the block, and
// the shifted-down remainder that spills into the next block.
module cr_prefix_fe_lane_split
  import cr_prefixPKG::*;
#(
  parameter int SPW = 11
) (
  input  logic [63:0]    data,
  input  logic [7:0]     vbytes,
  input  logic [SPW-1:0] space,
  output fe_split_t      split
);

  logic [3:0] n;
  logic [3:0] sp8;
  logic [3:0] take;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, vbytes[i]};
  end

  // Space beyond one word never limits the head, so clip it to 8.
  assign sp8  = (space >= SPW'(8)) ? 4'd8 : space[3:0];
  assign take = (n < sp8) ? n : sp8;

  always_comb begin
    split           = '0;
    split.n         = n;
    split.fill      = (SPW'(n) >= space);
    split.head_mask = fe_thermo(take);
    split.rem_cnt   = (n > sp8) ? 3'(n - sp8) : 3'd0;
    split.rem_data  = data >> {sp8[2:0], 3'b000};
  end

endmodule

// File: rtl/cr_prefix_fe_feeder.sv
// Re-slices a byte-valid word stream into 1 KB blocks for the match lanes.
// CR_PREFIX_FE_FEEDER_DRAIN_EN adds one idle cycle before every end-of-block.
module cr_prefix_fe_feeder
  import cr_prefixPKG::*;
#(
  parameter int BLK_BYTES = FE_BLK_BYTES,
  parameter int NUM_BLKS  = FE_NUM_BLKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_vbytes,
  input  logic        in_eof,
  output logic [63:0] fe_char_in,
  output logic [7:0]  fe_char_vbytes,
  output logic        fe_ctlr_eodb,
  output logic [1:0]  fe_sel_1k,
  output logic        frame_done,
  output logic        ovf
);

  localparam int         BW       = $clog2(BLK_BYTES) + 1;
  localparam logic [1:0] LAST_BLK = 2'(NUM_BLKS - 1);
`ifdef CR_PREFIX_FE_FEEDER_DRAIN_EN
  localparam fe_feeder_state_e CLOSE = ST_DRAIN;
`else
  localparam fe_feeder_state_e CLOSE = ST_EODB;
`endif

  fe_feeder_state_e state, state_n;
  logic [BW-1:0] bcnt, bcnt_n, space;
  logic [1:0]    blk, blk_n;
  logic          eof_seen, eof_n;
  logic [63:0]   hold, hold_n;
  logic [2:0]    hcnt, hcnt_n;
  logic [63:0]   char_n;
  logic [7:0]    vb_n;
  logic          eodb_n, done_n, ovf_n;
  logic [1:0]    sel_n;
  logic          accept;
  fe_split_t     split;

  assign space    = BW'(BLK_BYTES) - bcnt;
  assign in_ready = !rst && (state == ST_PASS || state == ST_DROP);
  assign accept   = in_valid && in_ready;

  cr_prefix_fe_lane_split #(.SPW(BW)) u_split (
    .data   (in_data),
    .vbytes (in_vbytes),
    .space  (space),
    .split  (split)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_PASS;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    blk_n   = blk;
    eof_n   = eof_seen;
    hold_n  = hold;
    hcnt_n  = hcnt;
    char_n  = '0;
    vb_n    = '0;
    eodb_n  = 1'b0;
    done_n  = 1'b0;
    ovf_n   = 1'b0;
    sel_n   = blk;
    case (state)
      ST_PASS: begin
        if (accept) begin
          char_n = in_data & fe_byte_mask(split.head_mask);
          vb_n   = split.head_mask;
          if (!split.fill) begin
            bcnt_n = bcnt + BW'(split.n);
            if (in_eof) begin
              eof_n   = 1'b1;
              state_n = CLOSE;
            end
          end else begin
            // Block is full; any overhang waits in hold for the next block.
            bcnt_n  = '0;
            eof_n   = in_eof;
            hold_n  = split.rem_data;
            hcnt_n  = split.rem_cnt;
            state_n = CLOSE;
          end
        end
      end
      ST_REM: begin
        char_n  = hold & fe_byte_mask(fe_thermo({1'b0, hcnt}));
        vb_n    = fe_thermo({1'b0, hcnt});
        bcnt_n  = BW'(hcnt);
        hcnt_n  = '0;
        state_n = eof_seen ? CLOSE : ST_PASS;
      end
`ifdef CR_PREFIX_FE_FEEDER_DRAIN_EN
      ST_DRAIN: state_n = ST_EODB;
`endif
      ST_EODB: begin
        eodb_n = 1'b1;
        bcnt_n = '0;
        if (eof_seen && hcnt == 3'd0) begin
          done_n  = 1'b1;
          blk_n   = '0;
          eof_n   = 1'b0;
          state_n = ST_PASS;
        end else if (blk == LAST_BLK) begin
          // No slot left: whatever remains of the frame is discarded.
          ovf_n  = 1'b1;
          hcnt_n = '0;
          if (eof_seen) begin
            blk_n   = '0;
            eof_n   = 1'b0;
            state_n = ST_PASS;
          end else begin
            state_n = ST_DROP;
          end
        end else begin
          blk_n   = blk + 2'd1;
          state_n = (hcnt != 3'd0) ? ST_REM : ST_PASS;
        end
      end
      ST_DROP: begin
        if (accept && in_eof) begin
          blk_n   = '0;
          state_n = ST_PASS;
        end
      end
      default: state_n = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt           <= '0;
      blk            <= '0;
      eof_seen       <= 1'b0;
      hold           <= '0;
      hcnt           <= '0;
      fe_char_in     <= '0;
      fe_char_vbytes <= '0;
      fe_ctlr_eodb   <= 1'b0;
      fe_sel_1k      <= '0;
      frame_done     <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      bcnt           <= bcnt_n;
      blk            <= blk_n;
      eof_seen       <= eof_n;
      hold           <= hold_n;
      hcnt           <= hcnt_n;
      fe_char_in     <= char_n;
      fe_char_vbytes <= vb_n;
      fe_ctlr_eodb   <= eodb_n;
      fe_sel_1k      <= sel_n;
      frame_done     <= done_n;
      ovf            <= ovf_n;
    end
  end

endmodule
